// File: rtl/plab2_proc_fetch_buffer_if.sv
// Handshake bundle between the fetch buffer, the F-stage PC logic, imem and D.
// The buffer takes the slave view; the surrounding pipeline/imem drives the master view.
interface plab2_proc_fetch_buffer_if;
    logic        fetch_val_F;
    logic        fetch_rdy_F;
    logic [31:0] fetch_addr_F;
    logic        squash_F;

    logic        imemreq_val;
    logic        imemreq_rdy;
    logic [31:0] imemreq_msg_addr;

    logic        imemresp_val;
    logic        imemresp_rdy;
    logic [31:0] imemresp_msg_data;

    logic        inst_val_D;
    logic        inst_rdy_D;
    logic [31:0] inst_D;

    modport slave (
        input  fetch_val_F, fetch_addr_F, squash_F,
        output fetch_rdy_F,
        output imemreq_val, imemreq_msg_addr,
        input  imemreq_rdy,
        input  imemresp_val, imemresp_msg_data,
        output imemresp_rdy,
        output inst_val_D, inst_D,
        input  inst_rdy_D
    );

    modport master (
        output fetch_val_F, fetch_addr_F, squash_F,
        input  fetch_rdy_F,
        input  imemreq_val, imemreq_msg_addr,
        output imemreq_rdy,
        output imemresp_val, imemresp_msg_data,
        input  imemresp_rdy,
        input  inst_val_D, inst_D,
        output inst_rdy_D
    );
endinterface

// File: rtl/plab2_proc_fetch_buffer.sv
// Credit-based instruction fetch buffer: issues imem requests, queues responses
// in order with a same-cycle bypass to D, and discards responses of squashed fetches.
module plab2_proc_fetch_buffer #(
    parameter int p_num_entries = 2,
    parameter int c_cnt_nbits   = $clog2(p_num_entries) + 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    domain,
    plab2_proc_fetch_buffer_if.slave bus
);
    localparam int DATA_W = 32;
    localparam int PTR_W  = $clog2(p_num_entries);
    localparam int SUM_W  = c_cnt_nbits + 1;

    typedef logic [c_cnt_nbits-1:0] cnt_t;
    typedef logic [PTR_W-1:0]       ptr_t;

    localparam cnt_t             CNT_ONE = cnt_t'(1);
    localparam ptr_t             PTR_ONE = ptr_t'(1);
    localparam logic [SUM_W-1:0] CAP     = SUM_W'(p_num_entries);

    cnt_t occ_q, occ_d;
    cnt_t inflight_q, inflight_d;
    cnt_t drop_q, drop_d;
    ptr_t head_q, head_d;
    ptr_t tail_q, tail_d;

    logic [DATA_W-1:0] mem_q [p_num_entries];

    logic [SUM_W-1:0] used;
    logic             credit_ok;
    logic             req_fire;
    logic             resp_fire;
    logic             resp_drop;
    logic             resp_keep;
    logic             empty;
    logic             bypass;
    logic             deq;
    logic             push;
    logic             pop;

    // The domain label only classifies the data; it never changes behaviour.
    logic unused_domain;
    assign unused_domain = domain;

    assign used      = {1'b0, occ_q} + {1'b0, inflight_q};
    assign credit_ok = used < CAP;
    assign empty     = (occ_q == '0);

    assign bus.fetch_rdy_F      = bus.imemreq_rdy && credit_ok;
    assign bus.imemreq_val      = bus.fetch_val_F && credit_ok;
    assign bus.imemreq_msg_addr = bus.fetch_addr_F;
    assign bus.imemresp_rdy     = !reset;

    assign req_fire  = bus.fetch_val_F && bus.fetch_rdy_F;
    assign resp_fire = bus.imemresp_val && bus.imemresp_rdy;
    assign resp_drop = resp_fire && (drop_q != '0);
    assign resp_keep = resp_fire && (drop_q == '0);
    assign bypass    = empty && resp_keep && !bus.squash_F;

    assign bus.inst_val_D = !bus.squash_F && (!empty || resp_keep);
    assign deq            = bus.inst_val_D && bus.inst_rdy_D;
    assign pop            = deq && !empty;
    assign push           = resp_keep && !bus.squash_F && !(bypass && bus.inst_rdy_D);

    always_comb begin
        bus.inst_D = '0;
        if (!empty) begin
            bus.inst_D = mem_q[head_q];
        end else if (bypass) begin
            bus.inst_D = bus.imemresp_msg_data;
        end
    end

    always_comb begin
        occ_d      = occ_q;
        head_d     = head_q;
        tail_d     = tail_q;
        drop_d     = drop_q;
        inflight_d = inflight_q + cnt_t'(req_fire) - cnt_t'(resp_fire);
        if (bus.squash_F) begin
            // Everything still outstanding (old or already-dropped) is on a dead
            // path; a request firing now is the new path and is not counted.
            occ_d  = '0;
            head_d = tail_q;
            drop_d = inflight_q - cnt_t'(resp_fire);
        end else begin
            occ_d = occ_q + cnt_t'(push) - cnt_t'(pop);
            if (push) begin
                tail_d = tail_q + PTR_ONE;
            end
            if (pop) begin
                head_d = head_q + PTR_ONE;
            end
            if (resp_drop) begin
                drop_d = drop_q - CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            occ_q      <= '0;
            inflight_q <= '0;
            drop_q     <= '0;
            head_q     <= '0;
            tail_q     <= '0;
        end else begin
            occ_q      <= occ_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[tail_q] <= bus.imemresp_msg_data;
        end
    end

endmodule

// File: tb/tb_plab2_proc_fetch_buffer.sv
// Randomized scoreboard bench for the fetch buffer: an epoch-tagged imem model
// predicts which instructions reach D and in what order.
module tb_plab2_proc_fetch_buffer;
    localparam int N    = 2;
    localparam int NCYC = 3200;

    logic clk    = 1'b0;
    logic reset  = 1'b1;
    logic domain = 1'b0;

    always #5 clk = ~clk;

    plab2_proc_fetch_buffer_if bus();

    plab2_proc_fetch_buffer #(.p_num_entries(N)) dut (
        .clk    (clk),
        .reset  (reset),
        .domain (domain),
        .bus    (bus)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          epoch;
    } req_t;

    req_t        pend[$];
    logic [31:0] exp_q[$];
    int          epoch  = 0;
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Stimulus, imem model and request-side checks.
    initial begin
        int   mode;
        logic squash;
        logic resp;
        logic room;
        req_t r;

        bus.fetch_val_F       = 1'b0;
        bus.fetch_addr_F      = '0;
        bus.squash_F          = 1'b0;
        bus.imemreq_rdy       = 1'b0;
        bus.imemresp_val      = 1'b0;
        bus.imemresp_msg_data = '0;
        bus.inst_rdy_D        = 1'b0;

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge clk);
            mode   = (cyc / 400) % 4;
            reset  = (cyc < 3) || ($urandom_range(0, 249) == 0);
            domain = $urandom_range(0, 1) == 1;
            squash = !reset && ($urandom_range(0, 99) < ((mode == 2) ? 20 : 6));
            bus.squash_F     = squash;
            bus.fetch_val_F  = $urandom_range(0, 99) < 75;
            bus.fetch_addr_F = $urandom & 32'hFFFF_FFFC;
            bus.imemreq_rdy  = $urandom_range(0, 99) < ((mode == 1) ? 50 : 85);
            bus.inst_rdy_D   = (mode == 3) ? (cyc % 2 == 0) : ($urandom_range(0, 99) < 60);
            resp = !reset && (pend.size() > 0) && ($urandom_range(0, 99) < 60);
            bus.imemresp_val      = resp;
            bus.imemresp_msg_data = resp ? pend[0].data : $urandom;
            #1;
            if (reset) begin
                exp_q.delete();
                pend.delete();
                check("imemresp_rdy_in_reset", bus.imemresp_rdy, 32'd0);
            end else begin
                room = (exp_q.size() + pend.size()) < N;
                check("fetch_rdy_F", bus.fetch_rdy_F, bus.imemreq_rdy && room);
                check("imemreq_val", bus.imemreq_val, bus.fetch_val_F && room);
                if (bus.fetch_val_F && room)
                    check("imemreq_msg_addr", bus.imemreq_msg_addr, bus.fetch_addr_F);
                check("imemresp_rdy", bus.imemresp_rdy, 32'd1);
                if (squash) begin
                    epoch++;
                    exp_q.delete();
                end
                if (resp) begin
                    r = pend.pop_front();
                    if (!squash && r.epoch == epoch)
                        exp_q.push_back(r.data);
                end
                if (bus.fetch_val_F && bus.imemreq_rdy && room) begin
                    r.addr  = bus.fetch_addr_F;
                    r.data  = $urandom;
                    r.epoch = epoch;
                    pend.push_back(r);
                end
            end
        end
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // D-side monitor: pops the scoreboard whenever D takes an instruction.
    initial begin
        logic        exp_val;
        logic [31:0] exp_d;
        forever begin
            @(negedge clk);
            #2;
            if (!reset) begin
                exp_val = (exp_q.size() > 0) && !bus.squash_F;
                check("inst_val_D", bus.inst_val_D, exp_val);
                if (bus.inst_val_D && bus.inst_rdy_D) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL inst_deq: got %h, expected no instruction (t=%0t)", bus.inst_D, $time);
                    end else begin
                        exp_d = exp_q.pop_front();
                        check("inst_D", bus.inst_D, exp_d);
                    end
                end else if (exp_val) begin
                    check("inst_D_head", bus.inst_D, exp_q[0]);
                end else if (!bus.squash_F) begin
                    check("inst_D_empty", bus.inst_D, 32'd0);
                end
            end
        end
    end

endmodule
